ram_bist_ctrl: RTL

- Synthesizable built-in self-test initiator for the simple dual-port block RAM IP (64x8, output-registered), on a single clock.
- Drives the RAM write port, then the read port, and checks every returned word against a generated pattern.
- Runs two passes: the true pattern, then its bitwise complement, so every cell bit is exercised at 0 and at 1.
- Reports busy/done/pass, a saturating error count and the first failing address; the RAM's rd_clk is tied to wr_clk at the top level.

---
 rtl/ram_bist_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
//   Built-in self-test initiator for a simple dual-port block RAM running on a
//   single clock. A run writes a generated pattern to every address, reads it
//   all back and checks each returned word, then repeats with the bitwise
//   complement so every cell bit is exercised at both 0 and 1.
//
//   Pattern: P(a,ph) = (all-ones - a) mod 2^DATA_WIDTH, inverted when ph=1.
//
// Ports
//   wr_clk          clock for the controller and both RAM ports
//   tb_wr_rst       asynchronous, active-high reset
//   start           begin a run (accepted only in IDLE or DONE)
//   busy            high while writing, reading or draining
//   done            high once a run has finished, until the next start
//   pass            valid with done: 1 when no mismatch was seen
//   err_cnt         saturating mismatch count
//   first_err_addr  address of the first mismatch of the run
//   ram_wr_en/_addr/_data   RAM write port (registered)
//   ram_rd_addr             RAM read address (registered)
//   ram_rd_data             RAM read data, sampled RD_LATENCY edges after the
//                           edge that updated ram_rd_addr
// ---------------------------------------------------------------------------
module ram_bist_ctrl #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 3,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     ram_wr_en,
    output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]    DATA_ZERO  = {DATA_WIDTH{1'b0}};
    localparam logic [2:0]               DRAIN_LAST = 3'(RD_LATENCY - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ZERO   = {ERR_CNT_WIDTH{1'b0}};
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE    = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = {ERR_CNT_WIDTH{1'b1}};

    // Test pattern for address a in phase ph.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic                  ph);
        logic [DATA_WIDTH-1:0] a_ext;
        logic [DATA_WIDTH-1:0] p;
        a_ext = DATA_WIDTH'(a);
        p     = {DATA_WIDTH{1'b1}} - a_ext;
        if (ph) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic [2:0]              drain_q, drain_d;
    logic                    run_clear_s;

    logic                    err_seen_q, err_seen_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_q, first_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;

    // Read-check pipeline: valid, address and phase of each outstanding read.
    logic [RD_LATENCY-1:0]                 pv_q, pv_d;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pa_q, pa_d;
    logic [RD_LATENCY-1:0]                 pp_q, pp_d;
    logic                                  mismatch_s;

    // FSM next state, address counter, phase and drain counter.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        drain_d     = drain_q;
        run_clear_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    addr_d      = ADDR_ZERO;
                    phase_d     = 1'b0;
                    drain_d     = 3'd0;
                    run_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_READ;
                    addr_d  = ADDR_ZERO;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_READ: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_DRAIN;
                    addr_d  = ADDR_ZERO;
                    drain_d = 3'd0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = 3'd0;
                    if (!phase_q) begin
                        state_d = ST_WRITE;
                        phase_d = 1'b1;
                        addr_d  = ADDR_ZERO;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = ADDR_ZERO;
                phase_d = 1'b0;
                drain_d = 3'd0;
            end
        endcase
    end

    // Read-data check, error bookkeeping, pipeline shift and registered outputs.
    // Outputs are derived from the next state so each flop holds the value that
    // belongs to the cycle the FSM is entering.
    always_comb begin
        mismatch_s = pv_q[RD_LATENCY-1] &&
                     (ram_rd_data != pattern(pa_q[RD_LATENCY-1], pp_q[RD_LATENCY-1]));
        err_cnt_d  = err_cnt_q;
        first_d    = first_q;
        err_seen_d = err_seen_q;
        if (run_clear_s) begin
            err_cnt_d  = ERR_ZERO;
            first_d    = ADDR_ZERO;
            err_seen_d = 1'b0;
        end else if (mismatch_s) begin
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (!err_seen_q) begin
                err_seen_d = 1'b1;
                first_d    = pa_q[RD_LATENCY-1];
            end else begin
                first_d = first_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end

        pv_d    = pv_q;
        pa_d    = pa_q;
        pp_d    = pp_q;
        pv_d[0] = (state_d == ST_READ);
        pa_d[0] = addr_d;
        pp_d[0] = phase_d;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pp_d[i] = pp_q[i-1];
        end

        busy_d  = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
        pass_d  = (state_d == ST_DONE) && (err_cnt_d == ERR_ZERO);
        wr_en_d = (state_d == ST_WRITE);
        if (state_d == ST_WRITE) begin
            wr_addr_d = addr_d;
            wr_data_d = pattern(addr_d, phase_d);
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
        if (state_d == ST_READ) begin
            rd_addr_d = addr_d;
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= ADDR_ZERO;
            phase_q    <= 1'b0;
            drain_q    <= 3'd0;
            err_seen_q <= 1'b0;
            err_cnt_q  <= ERR_ZERO;
            first_q    <= ADDR_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= ADDR_ZERO;
            wr_data_q  <= DATA_ZERO;
            rd_addr_q  <= ADDR_ZERO;
            pv_q       <= '0;
            pa_q       <= '0;
            pp_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            drain_q    <= drain_d;
            err_seen_q <= err_seen_d;
            err_cnt_q  <= err_cnt_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            pv_q       <= pv_d;
            pa_q       <= pa_d;
            pp_q       <= pp_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_q;
    assign ram_wr_en      = wr_en_q;
    assign ram_wr_addr    = wr_addr_q;
    assign ram_wr_data    = wr_data_q;
    assign ram_rd_addr    = rd_addr_q;

endmodule
